mux_n_arb_reg: RTL and testbench
================================

// Module: mux_n_arb_reg
// PURPOSE
//  N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
//  Generalises the 2:1 combinational bus mux. Mode 0 forwards the channel on the select bus.
//  Mode 1 arbitrates round-robin among requesting channels.
//  Sits between datapath sources and one shared consumer (register file, ALU or bus port).
// PARAMETERS
//  NUM_CHANNELS            4   number of input channels, 2..16
//  DATAWIDTH_BUS           6   data width per channel
//  DATAWIDTH_MUX_SELECTION 2   select width = $clog2(NUM_CHANNELS)
// PORTS
//  CC_MUX_CLOCK_50         in   1     clock, rising edge
//  CC_MUX_RESET_InHigh     in   1     synchronous reset, active high
//  CC_MUX_data_InBUS       in   N*W   packed inputs; channel k = bits [k*W +: W]
//  CC_MUX_valid_InBUS      in   N     per-channel valid
//  CC_MUX_ready_OutBUS     out  N     per-channel ready (combinational, one-hot or zero)
//  CC_MUX_mode_In          in   1     0 = fixed select, 1 = round-robin
//  CC_MUX_selection_InBUS  in   S     channel index used in mode 0
//  CC_MUX_data_OutBUS      out  W     registered output data
//  CC_MUX_valid_Out        out  1     output holds a word
//  CC_MUX_channel_OutBUS   out  S     source channel of the held word
//  CC_MUX_ready_In         in   1     consumer accepts the word
// BEHAVIOUR
//  - Reset is synchronous and active high. Output state after reset:
//    data_Out=0, valid_Out=0, channel_Out=0, RR pointer=0.
//    Reset mid-operation discards the held word.
//  - Two-state FSM with one output register:
//    EMPTY -> FULL on grant.
//    FULL -> EMPTY on valid_Out & ready_In with no new grant.
//    FULL -> FULL on drain+grant, or on stall.
//  - can_accept = EMPTY | ready_In (same-cycle drain and refill; 1 word/cycle throughput).
//  - Grant (combinational):
//    Mode 0: channel = selection, granted iff valid[sel] & can_accept.
//      If selection >= N, channel 0 is used (default-to-channel-0 rule).
//    Mode 1: first requesting channel scanning ptr, ptr+1, ... mod N.
//      On grant of k, ptr <= (k+1) mod N. Ptr is unchanged with no grant.
//  - ready_Out[k]=1 only for the granted channel. A transfer on channel k is valid[k]&ready_Out[k].
//  - Latency: accepted word appears on data_Out/channel_Out one clock after the transfer edge.
//  - Stall: while valid_Out & !ready_In, data_Out, channel_Out and valid_Out are held stable.
//    All ready_Out are 0 during a stall.
//  - Mode or selection changes take effect on the next grant decision.
//    They never alter a held word. The RR pointer is kept across mode changes.
//  - No valid input and EMPTY: outputs are held, and valid_Out stays 0.
// TESTING
//  1 Reset: assert reset 2 cycles with all valid=1.
//    -> valid_Out=0, data_Out=0, channel_Out=0, all ready_Out=0 while in reset.
//  2 Mode 0, sel=2, ch2=6'h15 valid, ready_In=1.
//    -> ready_Out=4'b0100. Next cycle data_Out=6'h15, channel_Out=2.
//  3 Mode 1, all 4 valid, ready_In=1 for 8 cycles.
//    -> grants 0,1,2,3,0,1,2,3. Outputs follow one cycle later.
//  4 Backpressure: FULL with 6'h2A, ready_In=0 for 3 cycles.
//    -> data_Out stays 6'h2A, ready_Out=0. Then ready_In=1 -> drain and refill in the same cycle.
//  5 Mode 0, sel=1, valid[1]=0, others valid.
//    -> no grant, valid_Out falls to 0 after drain.
//  6 Reset while FULL with ready_In=0.
//    -> next cycle valid_Out=0 and the RR pointer is 0 (next RR grant goes to ch0 if valid).

Source files
------------

// File: rtl/mux_n_arb_reg.sv
// mux_n_arb_reg: N-channel registered mux with valid/ready handshake, fixed-select or round-robin grant
module mux_n_arb_reg #(
   parameter int NUM_CHANNELS            = 4,
   parameter int DATAWIDTH_BUS           = 6,
   parameter int DATAWIDTH_MUX_SELECTION = 2
) (
   input  logic                                     CC_MUX_CLOCK_50,
   input  logic                                     CC_MUX_RESET_InHigh,
   input  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0]    CC_MUX_data_InBUS,
   input  logic [NUM_CHANNELS-1:0]                  CC_MUX_valid_InBUS,
   output logic [NUM_CHANNELS-1:0]                  CC_MUX_ready_OutBUS,
   input  logic                                     CC_MUX_mode_In,
   input  logic [DATAWIDTH_MUX_SELECTION-1:0]       CC_MUX_selection_InBUS,
   output logic [DATAWIDTH_BUS-1:0]                 CC_MUX_data_OutBUS,
   output logic                                     CC_MUX_valid_Out,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]       CC_MUX_channel_OutBUS,
   input  logic                                     CC_MUX_ready_In
);
   localparam int N = NUM_CHANNELS;
   localparam int W = DATAWIDTH_BUS;
   localparam int S = DATAWIDTH_MUX_SELECTION;
   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;
   logic         state, can_accept, rr_found, gnt;
   logic [S-1:0] sel, rr_ch, idx, gnt_ch, ptr;
   logic [W-1:0] ch_data [N];
   for (genvar k = 0; k < N; k++) begin : g_unpack
      assign ch_data[k] = CC_MUX_data_InBUS[k*W +: W];
   end
   // round-robin scan starting at ptr, wrapping modulo N
   always_comb begin
      rr_found = 1'b0;
      rr_ch    = '0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         idx = S'((int'(ptr) + i) % N);
         if (!rr_found && CC_MUX_valid_InBUS[idx]) begin
            rr_found = 1'b1;
            rr_ch    = idx;
         end
      end
   end
   always_comb begin
      sel        = (int'(CC_MUX_selection_InBUS) < N) ? CC_MUX_selection_InBUS : '0;
      can_accept = (state == EMPTY) | CC_MUX_ready_In;
      gnt_ch     = CC_MUX_mode_In ? rr_ch : sel;
      gnt        = !CC_MUX_RESET_InHigh & can_accept & (CC_MUX_mode_In ? rr_found : CC_MUX_valid_InBUS[sel]);
      CC_MUX_ready_OutBUS = gnt ? ({{(N-1){1'b0}}, 1'b1} << gnt_ch) : '0;
   end
   assign CC_MUX_valid_Out = (state == FULL);
   always_ff @(posedge CC_MUX_CLOCK_50) begin
      if (CC_MUX_RESET_InHigh) begin
         state                 <= EMPTY;
         CC_MUX_data_OutBUS    <= '0;
         CC_MUX_channel_OutBUS <= '0;
         ptr                   <= '0;
      end else if (gnt) begin
         state                 <= FULL;
         CC_MUX_data_OutBUS    <= ch_data[gnt_ch];
         CC_MUX_channel_OutBUS <= gnt_ch;
         if (CC_MUX_mode_In)
            ptr <= (int'(gnt_ch) == N - 1) ? '0 : gnt_ch + 1'b1;
      end else if (CC_MUX_ready_In) begin
         state <= EMPTY;
      end
   end
endmodule

// File: tb/tb_mux_n_arb_reg.sv
// tb_mux_n_arb_reg: directed and randomized checks of mux_n_arb_reg against a behavioural model
module tb_mux_n_arb_reg;
   logic        clk = 1'b0;
   logic        rst;
   logic [23:0] data_in;
   logic [3:0]  valid_in;
   logic [3:0]  ready_out;
   logic        mode;
   logic [1:0]  sel;
   logic [5:0]  data_out;
   logic        valid_out;
   logic [1:0]  ch_out;
   logic        ready_in;
   int          errors = 0;
   int          checks = 0;
   bit          started = 1'b0;
   bit          m_full = 1'b0;
   logic [5:0]  m_data = '0;
   int          m_ch = 0;
   int          m_ptr = 0;
   bit          e_gnt;
   int          e_ch;

   mux_n_arb_reg dut (
      .CC_MUX_CLOCK_50       (clk),
      .CC_MUX_RESET_InHigh   (rst),
      .CC_MUX_data_InBUS     (data_in),
      .CC_MUX_valid_InBUS    (valid_in),
      .CC_MUX_ready_OutBUS   (ready_out),
      .CC_MUX_mode_In        (mode),
      .CC_MUX_selection_InBUS(sel),
      .CC_MUX_data_OutBUS    (data_out),
      .CC_MUX_valid_Out      (valid_out),
      .CC_MUX_channel_OutBUS (ch_out),
      .CC_MUX_ready_In       (ready_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // which channel the rules grant this cycle, given the model's held state
   function automatic void predict();
      bit can;
      int s;
      can   = !m_full || ready_in;
      e_gnt = 1'b0;
      e_ch  = 0;
      if (rst || !can) return;
      if (!mode) begin
         s = (int'(sel) < 4) ? int'(sel) : 0;
         e_gnt = valid_in[s];
         e_ch  = s;
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (!e_gnt && valid_in[(m_ptr + j) % 4]) begin
               e_gnt = 1'b1;
               e_ch  = (m_ptr + j) % 4;
            end
         end
      end
   endfunction

   always @(posedge clk) begin
      predict();
      if (rst) begin
         m_full <= 1'b0;
         m_data <= '0;
         m_ch   <= 0;
         m_ptr  <= 0;
      end else if (e_gnt) begin
         m_full <= 1'b1;
         m_data <= data_in[e_ch*6 +: 6];
         m_ch   <= e_ch;
         if (mode) m_ptr <= (e_ch + 1) % 4;
      end else if (ready_in) begin
         m_full <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         predict();
         check("model_ready", ready_out, e_gnt ? (32'd1 << e_ch) : 32'd0);
         check("model_valid", valid_out, m_full);
         check("model_data", data_out, m_data);
         check("model_channel", ch_out, m_ch);
      end
   end

   initial begin
      rst = 1'b1; mode = 1'b0; sel = 2'd0; valid_in = 4'hF; ready_in = 1'b1;
      data_in = 24'(($urandom() << 1) ^ $urandom());
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_ready", ready_out, 0);
         check("rst_valid", valid_out, 0);
         check("rst_data", data_out, 0);
         check("rst_channel", ch_out, 0);
      end
      started = 1'b1;
      step();
      rst = 1'b0; mode = 1'b0; sel = 2'd2; valid_in = 4'b0100; data_in = 24'h15 << 12;
      @(negedge clk);
      check("sel2_ready", ready_out, 4'b0100);
      step();
      check("sel2_data", data_out, 6'h15);
      check("sel2_channel", ch_out, 2);
      check("sel2_valid", valid_out, 1);
      mode = 1'b1; valid_in = 4'hF; data_in = {6'h0B, 6'h0A, 6'h09, 6'h08};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rr_ready", ready_out, 32'd1 << (i % 4));
         step();
         check("rr_channel", ch_out, i % 4);
         check("rr_data", data_out, 8 + (i % 4));
      end
      mode = 1'b0; sel = 2'd1; valid_in = 4'b0010; data_in = 24'h2A << 6;
      step();
      check("bp_fill", data_out, 6'h2A);
      ready_in = 1'b0; valid_in = 4'hF;
      repeat (3) begin
         @(negedge clk);
         check("bp_ready", ready_out, 0);
         check("bp_data", data_out, 6'h2A);
         check("bp_valid", valid_out, 1);
         step();
      end
      check("bp_hold", data_out, 6'h2A);
      ready_in = 1'b1; sel = 2'd3; data_in = 24'h33 << 18;
      @(negedge clk);
      check("refill_ready", ready_out, 4'b1000);
      step();
      check("refill_data", data_out, 6'h33);
      check("refill_channel", ch_out, 3);
      check("refill_valid", valid_out, 1);
      sel = 2'd1; valid_in = 4'b1101;
      @(negedge clk);
      check("nogrant_ready", ready_out, 0);
      step();
      check("nogrant_valid", valid_out, 0);
      mode = 1'b1; valid_in = 4'b0010; data_in = 24'h11 << 6;
      step();
      check("ptr_move_channel", ch_out, 1);
      ready_in = 1'b0; rst = 1'b1; valid_in = 4'h0;
      step();
      check("rst_full_valid", valid_out, 0);
      rst = 1'b0; mode = 1'b1; valid_in = 4'hF; ready_in = 1'b1;
      @(negedge clk);
      check("rst_ptr_ready", ready_out, 4'b0001);
      step();
      repeat (3000) begin
         rst      = ($urandom_range(0, 63) == 0);
         mode     = 1'($urandom_range(0, 1));
         sel      = 2'($urandom_range(0, 3));
         valid_in = 4'($urandom_range(0, 15));
         data_in  = 24'($urandom());
         ready_in = ($urandom_range(0, 3) != 0);
         step();
      end
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
